sbit_cluster_serializer: RTL and testbench

- Sits directly downstream of the S-bit one-shot stage in cluster building.
- Once per bunch crossing, latches the NSBITS-wide vector of one-shot-qualified S-bit pulses.
- Over the following fast-clock cycles, extracts up to MAX_CLUSTERS clusters of adjacent hits, lowest address first, and emits them serially as (address, size) words for the cluster packer.

---
 rtl/sbit_cluster_serializer.sv | 191 +++++++++++++++++++
 tb/tb_sbit_cluster_serializer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbit_cluster_serializer.sv
// Cluster serializer for one-shot qualified S-bits.
// Once per bunch crossing the pulse vector is latched into a work register.
// Each following clock strips the lowest run of adjacent hits (up to MAXSIZE
// strips, no wrap past the top strip) and emits it as an (address, size-1)
// word. A frame ends after the work register empties or MAX_CLUSTERS words.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a strobe; an empty strobe reports frame_done at once
// SCAN  | extracting one cluster per clock from the work register
// FLUSH | empty strobe accepted on a frame's last cycle; its frame_done is
//       | reported one clock later, otherwise behaves like IDLE
module sbit_cluster_serializer #(
  parameter int NSBITS       = 64,
  parameter int ADRB         = 6,
  parameter int MAX_CLUSTERS = 4,
  parameter int MAXSIZE      = 8,
  parameter int SIZEB        = 3,
  parameter int CNTB         = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NSBITS-1:0] sbits,
  input  logic              sbits_valid,
  output logic              ready,
  output logic              cluster_valid,
  output logic [ADRB-1:0]   cluster_adr,
  output logic [SIZEB-1:0]  cluster_size,
  output logic              frame_done,
  output logic [SIZEB:0]    cluster_count,
  output logic              overflow,
  output logic [CNTB-1:0]   drop_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [SIZEB:0] LAST_IDX = (SIZEB+1)'(MAX_CLUSTERS - 1);

  state_t             state_q, state_d;
  logic [NSBITS-1:0]  work_q, work_d;
  logic [SIZEB:0]     cnt_q, cnt_d;
  logic               cv_d, fd_d, ov_d;
  logic [ADRB-1:0]    adr_d;
  logic [SIZEB-1:0]   size_d;
  logic [SIZEB:0]     ccount_d;

  // Lowest-run finder: start address, capped run length and remaining work
  int                 run_adr;
  int                 run_len;
  logic               run_found;
  logic [NSBITS-1:0]  work_rem;
  logic               remaining;
  logic               final_cyc;

  // Locate the lowest set bit and measure the run above it in one pass
  always_comb begin
    logic stop;
    run_found = 1'b0;
    run_adr   = 0;
    run_len   = 0;
    stop      = 1'b0;
    for (int i = 0; i < NSBITS; i++) begin
      if (!run_found && work_q[i]) begin
        run_found = 1'b1;
        run_adr   = i;
        run_len   = 1;
      end else if (run_found && !stop) begin
        if (work_q[i] && run_len < MAXSIZE) run_len = run_len + 1;
        else                                stop    = 1'b1;
      end
    end
  end

  // Clear the extracted run; what is left becomes next cycle's work
  always_comb begin
    work_rem = work_q;
    for (int i = 0; i < NSBITS; i++) begin
      if (run_found && i >= run_adr && i < run_adr + run_len) work_rem[i] = 1'b0;
    end
    remaining = |work_rem;
    final_cyc = !remaining || (cnt_q == LAST_IDX);
  end

  // Next-state and registered-output values
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    cv_d     = 1'b0;
    fd_d     = 1'b0;
    ov_d     = 1'b0;
    adr_d    = cluster_adr;
    size_d   = cluster_size;
    ccount_d = cluster_count;
    ready    = 1'b0;

    case (state_q)
      IDLE, FLUSH: begin
        ready   = 1'b1;
        state_d = IDLE;
        if (state_q == FLUSH) begin
          fd_d     = 1'b1;
          ccount_d = '0;
        end
        if (sbits_valid) begin
          if (|sbits) begin
            work_d  = sbits;
            cnt_d   = '0;
            state_d = SCAN;
          end else if (state_q == FLUSH) begin
            // this edge already carries the previous empty frame's done
            state_d = FLUSH;
          end else begin
            fd_d     = 1'b1;
            ccount_d = '0;
          end
        end
      end

      SCAN: begin
        cv_d   = 1'b1;
        adr_d  = ADRB'(run_adr);
        size_d = SIZEB'(run_len - 1);
        work_d = work_rem;
        cnt_d  = cnt_q + 1'b1;
        if (final_cyc) begin
          ready    = 1'b1;
          fd_d     = 1'b1;
          ccount_d = cnt_q + 1'b1;
          ov_d     = remaining;
          state_d  = IDLE;
          work_d   = '0;
          if (sbits_valid) begin
            if (|sbits) begin
              work_d  = sbits;
              cnt_d   = '0;
              state_d = SCAN;
            end else begin
              state_d = FLUSH;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        work_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, work register and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      work_q        <= '0;
      cnt_q         <= '0;
      cluster_valid <= 1'b0;
      cluster_adr   <= '0;
      cluster_size  <= '0;
      frame_done    <= 1'b0;
      cluster_count <= '0;
      overflow      <= 1'b0;
    end else begin
      state_q       <= state_d;
      work_q        <= work_d;
      cnt_q         <= cnt_d;
      cluster_valid <= cv_d;
      cluster_adr   <= adr_d;
      cluster_size  <= size_d;
      frame_done    <= fd_d;
      cluster_count <= ccount_d;
      overflow      <= ov_d;
    end
  end

  // Saturating count of strobes that arrive while busy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (sbits_valid && !ready && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sbit_cluster_serializer.sv
// Directed bench for sbit_cluster_serializer with hand-computed expectations.
module tb_sbit_cluster_serializer;

  logic        clk;
  logic        reset_n;
  logic [63:0] sbits;
  logic        sbits_valid;
  logic        ready;
  logic        cluster_valid;
  logic [5:0]  cluster_adr;
  logic [2:0]  cluster_size;
  logic        frame_done;
  logic [3:0]  cluster_count;
  logic        overflow;
  logic [15:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  sbit_cluster_serializer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sbits         (sbits),
    .sbits_valid   (sbits_valid),
    .ready         (ready),
    .cluster_valid (cluster_valid),
    .cluster_adr   (cluster_adr),
    .cluster_size  (cluster_size),
    .frame_done    (frame_done),
    .cluster_count (cluster_count),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [63:0] v);
    sbits       = v;
    sbits_valid = 1'b1;
    tick();
    sbits_valid = 1'b0;
    sbits       = '0;
  endtask

  task automatic test_reset();
    reset_n     = 1'b1;
    sbits       = '0;
    sbits_valid = 1'b0;
    #2 reset_n = 1'b0;
    #2;
    checks++;
    if (cluster_valid !== 1'b0 || frame_done !== 1'b0 || overflow !== 1'b0 ||
        cluster_adr !== 6'd0 || cluster_size !== 3'd0 || cluster_count !== 4'd0 ||
        drop_cnt !== 16'd0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: cv=%0b fd=%0b ov=%0b adr=%0d size=%0d cnt=%0d drop=%0d rdy=%0b, required 0 0 0 0 0 0 0 1",
               cluster_valid, frame_done, overflow, cluster_adr, cluster_size, cluster_count, drop_cnt, ready);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    strobe(64'h0000_0000_0010_0038);
    checks++;
    if (cluster_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: cv=%0b fd=%0b, required 0 0", cluster_valid, frame_done);
    end
    tick();
    checks++;
    if (cluster_valid !== 1'b1 || cluster_adr !== 6'd3 || cluster_size !== 3'd2 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_c0: cv=%0b adr=%0d size=%0d fd=%0b, required 1 3 2 0",
               cluster_valid, cluster_adr, cluster_size, frame_done);
    end
    tick();
    checks++;
    if (cluster_valid !== 1'b1 || cluster_adr !== 6'd20 || cluster_size !== 3'd0 ||
        frame_done !== 1'b1 || cluster_count !== 4'd2 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_c1: cv=%0b adr=%0d size=%0d fd=%0b cnt=%0d ov=%0b, required 1 20 0 1 2 0",
               cluster_valid, cluster_adr, cluster_size, frame_done, cluster_count, overflow);
    end
    tick();
    checks++;
    if (cluster_valid !== 1'b0 || frame_done !== 1'b0 || cluster_adr !== 6'd20) begin
      errors++;
      $display("FAIL basic_after: cv=%0b fd=%0b adr=%0d, required 0 0 20", cluster_valid, frame_done, cluster_adr);
    end
  endtask

  task automatic test_split();
    strobe(64'h0000_0000_003F_FC00);
    tick();
    checks++;
    if (cluster_valid !== 1'b1 || cluster_adr !== 6'd10 || cluster_size !== 3'd7 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL split_c0: cv=%0b adr=%0d size=%0d fd=%0b, required 1 10 7 0",
               cluster_valid, cluster_adr, cluster_size, frame_done);
    end
    tick();
    checks++;
    if (cluster_valid !== 1'b1 || cluster_adr !== 6'd18 || cluster_size !== 3'd3 ||
        frame_done !== 1'b1 || cluster_count !== 4'd2 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL split_c1: cv=%0b adr=%0d size=%0d fd=%0b cnt=%0d ov=%0b, required 1 18 3 1 2 0",
               cluster_valid, cluster_adr, cluster_size, frame_done, cluster_count, overflow);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [5:0] exp_adr [4];
    exp_adr = '{6'd0, 6'd2, 6'd4, 6'd6};
    strobe(64'h8000_0000_0000_0155);
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (cluster_valid !== 1'b1 || cluster_adr !== exp_adr[n] || cluster_size !== 3'd0 ||
          frame_done !== (n == 3) || overflow !== (n == 3)) begin
        errors++;
        $display("FAIL overflow_c%0d: cv=%0b adr=%0d size=%0d fd=%0b ov=%0b, required 1 %0d 0 %0b %0b",
                 n, cluster_valid, cluster_adr, cluster_size, frame_done, overflow, exp_adr[n], n == 3, n == 3);
      end
    end
    checks++;
    if (cluster_count !== 4'd4) begin
      errors++;
      $display("FAIL overflow_count: cnt=%0d, required 4", cluster_count);
    end
    tick();
    checks++;
    if (cluster_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL overflow_after: cv=%0b fd=%0b, required 0 0", cluster_valid, frame_done);
    end
  endtask

  task automatic test_empty();
    strobe(64'd0);
    checks++;
    if (cluster_valid !== 1'b0 || frame_done !== 1'b1 || cluster_count !== 4'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL empty_done: cv=%0b fd=%0b cnt=%0d ov=%0b, required 0 1 0 0",
               cluster_valid, frame_done, cluster_count, overflow);
    end
    tick();
    checks++;
    if (cluster_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL empty_after: cv=%0b fd=%0b, required 0 0", cluster_valid, frame_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] fv [3];
    logic [5:0]  ea [3][4];
    logic [5:0]  e;
    fv = '{64'h55, 64'hAA, 64'h15400};
    ea = '{'{6'd0, 6'd2, 6'd4, 6'd6}, '{6'd1, 6'd3, 6'd5, 6'd7}, '{6'd10, 6'd12, 6'd14, 6'd16}};
    for (int c = 0; c < 14; c++) begin
      sbits_valid = (c % 4 == 0) && (c < 12);
      sbits       = (c < 12) ? fv[c / 4] : 64'd0;
      tick();
      if (c >= 1 && c <= 12) begin
        e = ea[(c - 1) / 4][(c - 1) % 4];
        checks++;
        if (cluster_valid !== 1'b1 || cluster_adr !== e || cluster_size !== 3'd0 ||
            frame_done !== (c % 4 == 0)) begin
          errors++;
          $display("FAIL b2b_cycle%0d: cv=%0b adr=%0d size=%0d fd=%0b, required 1 %0d 0 %0b",
                   c, cluster_valid, cluster_adr, cluster_size, frame_done, e, c % 4 == 0);
        end
        if (c % 4 == 0) begin
          checks++;
          if (cluster_count !== 4'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done%0d: cnt=%0d ov=%0b, required 4 0", c, cluster_count, overflow);
          end
        end
      end else begin
        checks++;
        if (cluster_valid !== 1'b0 || frame_done !== 1'b0) begin
          errors++;
          $display("FAIL b2b_quiet%0d: cv=%0b fd=%0b, required 0 0", c, cluster_valid, frame_done);
        end
      end
    end
    sbits_valid = 1'b0;
    sbits       = '0;
    checks++;
    if (drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL b2b_drop: drop=%0d, required 0", drop_cnt);
    end
  endtask

  task automatic test_drop();
    logic [5:0] exp_adr [4];
    exp_adr = '{6'd0, 6'd2, 6'd4, 6'd6};
    strobe(64'h55);
    for (int n = 0; n < 4; n++) begin
      if (n == 1) begin
        sbits_valid = 1'b1;
        sbits       = '1;
      end
      tick();
      sbits_valid = 1'b0;
      sbits       = '0;
      checks++;
      if (cluster_valid !== 1'b1 || cluster_adr !== exp_adr[n] || cluster_size !== 3'd0 ||
          frame_done !== (n == 3)) begin
        errors++;
        $display("FAIL drop_c%0d: cv=%0b adr=%0d size=%0d fd=%0b, required 1 %0d 0 %0b",
                 n, cluster_valid, cluster_adr, cluster_size, frame_done, exp_adr[n], n == 3);
      end
    end
    checks++;
    if (cluster_count !== 4'd4 || overflow !== 1'b0 || drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL drop_summary: cnt=%0d ov=%0b drop=%0d, required 4 0 1", cluster_count, overflow, drop_cnt);
    end
    tick();
    checks++;
    if (cluster_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL drop_after: cv=%0b fd=%0b, required 0 0", cluster_valid, frame_done);
    end
  endtask

  task automatic test_top_edge();
    strobe(64'hF000_0000_0000_0000);
    tick();
    checks++;
    if (cluster_valid !== 1'b1 || cluster_adr !== 6'd60 || cluster_size !== 3'd3 ||
        frame_done !== 1'b1 || cluster_count !== 4'd1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL top_edge: cv=%0b adr=%0d size=%0d fd=%0b cnt=%0d ov=%0b, required 1 60 3 1 1 0",
               cluster_valid, cluster_adr, cluster_size, frame_done, cluster_count, overflow);
    end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    strobe(64'h55);
    tick();
    checks++;
    if (cluster_valid !== 1'b1 || cluster_adr !== 6'd0) begin
      errors++;
      $display("FAIL midrst_pre: cv=%0b adr=%0d, required 1 0", cluster_valid, cluster_adr);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (cluster_valid !== 1'b0 || frame_done !== 1'b0 || overflow !== 1'b0 ||
        cluster_adr !== 6'd0 || cluster_size !== 3'd0 || cluster_count !== 4'd0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midrst_async: cv=%0b fd=%0b ov=%0b adr=%0d size=%0d cnt=%0d drop=%0d, required all 0",
               cluster_valid, frame_done, overflow, cluster_adr, cluster_size, cluster_count, drop_cnt);
    end
    tick();
    tick();
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (cluster_valid !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrst_release: active cycles=%0d, required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_split();
    test_overflow();
    test_empty();
    test_back_to_back();
    test_drop();
    test_top_edge();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
